// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine.
//   gcd_state_e : controller states (IDLE/CALC/DONE); the 2-bit encoding leaves
//                 one unused value, which the controller maps back to IDLE.
//   MODE_SUB / MODE_BIN : algorithm selectors for the MODE parameter.
//   k_width()  : width of the common power-of-two exponent k used by the
//                binary algorithm.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_e;

    localparam int MODE_SUB = 0;
    localparam int MODE_BIN = 1;

    // k counts shared factors of two; it can never exceed WIDTH-1, so
    // clog2(WIDTH)+1 bits always hold it.
    function automatic int k_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_if.sv
// Operand/result bundle of the GCD engine.
//   Handshake rule (both directions): a transfer happens on a rising clock
//   edge where valid and ready are both high. The source holds valid and its
//   data stable until that edge; ready may be raised or lowered at any time.
//   in_valid/in_ready/a_in/b_in : operand channel (producer -> engine)
//   out_valid/out_ready/gcd_out/cycles_out/zero_err : result channel
//   abort     : cancels a running computation
//   busy      : engine is iterating
//   dbg_state : current controller state, for observation only
// Modports: slave = engine side, master = producer/consumer side.
interface gcd_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CYC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             abort;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic [CYC_W-1:0] cycles_out;
    logic             zero_err;
    gcd_state_e       dbg_state;

    modport slave (
        input  in_valid, a_in, b_in, abort, out_ready,
        output in_ready, busy, out_valid, gcd_out, cycles_out, zero_err, dbg_state
    );

    modport master (
        output in_valid, a_in, b_in, abort, out_ready,
        input  in_ready, busy, out_valid, gcd_out, cycles_out, zero_err, dbg_state
    );
endinterface

// File: rtl/gcd_step.sv
// One combinational GCD iteration.
//   a_i, b_i  : current operand pair
//   k_i       : current shared power-of-two exponent (binary mode only)
//   a_o, b_o, k_o : values after this iteration (unchanged when terminating)
//   term_o    : pair is finished (A==0, B==0 or A==B); result is (A|B)<<k
// MODE selects subtractive (MODE_SUB) or binary/Stein (MODE_BIN) stepping.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = MODE_SUB,
    localparam int KW   = k_width(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [KW-1:0]    k_o,
    output logic             term_o
);

    always_comb begin
        a_o    = a_i;
        b_o    = b_i;
        k_o    = k_i;
        term_o = 1'b0;
        if ((a_i == '0) || (b_i == '0) || (a_i == b_i)) begin
            term_o = 1'b1;
        end else if (MODE == MODE_SUB) begin
            // The larger value is always the minuend, so no underflow.
            if (a_i > b_i) a_o = a_i - b_i;
            else           b_o = b_i - a_i;
        end else begin
            if (!a_i[0] && !b_i[0]) begin
                a_o = a_i >> 1;
                b_o = b_i >> 1;
                k_o = k_i + KW'(1);
            end else if (!a_i[0]) begin
                a_o = a_i >> 1;
            end else if (!b_i[0]) begin
                b_o = b_i >> 1;
            end else if (a_i > b_i) begin
                a_o = a_i - b_i;
            end else begin
                b_o = b_i - a_i;
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine: controller, operand registers, iteration counter and result
// registers around a single gcd_step instance.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : gcd_if slave port (operand channel, result channel, abort, busy,
//         dbg_state)
// Flow: IDLE accepts operands -> CALC iterates one step per cycle -> DONE
// presents the result until the consumer takes it -> IDLE.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CYC_W = 16,
    parameter int MODE  = MODE_SUB,
    localparam int KW   = k_width(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    gcd_if.slave bus
);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             zerr_q, zerr_d;

    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_b;
    logic [KW-1:0]    step_k;
    logic             step_term;
    logic [CYC_W-1:0] cnt_inc;

    gcd_step #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_step (
        .a_i    (a_q),
        .b_i    (b_q),
        .k_i    (k_q),
        .a_o    (step_a),
        .b_o    (step_b),
        .k_o    (step_k),
        .term_o (step_term)
    );

    // Iteration counter saturates at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CYC_W'(1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        cyc_d   = cyc_q;
        zerr_d  = zerr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_inc;
                // abort wins over a terminating step: no result is produced.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (step_term) begin
                    gcd_d   = (a_q | b_q) << k_q;
                    zerr_d  = (a_q == '0) && (b_q == '0);
                    cyc_d   = cnt_inc;
                    state_d = ST_DONE;
                end else begin
                    a_d = step_a;
                    b_d = step_b;
                    k_d = step_k;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            cyc_q   <= '0;
            zerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            cyc_q   <= cyc_d;
            zerr_q  <= zerr_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.busy       = (state_q == ST_CALC);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.gcd_out    = gcd_q;
    assign bus.cycles_out = cyc_q;
    assign bus.zero_err   = zerr_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: six instances (WIDTH 16/8/32, both MODEs) run in
// lockstep on shared handshake controls; each has its own operands.
// A negedge monitor predicts every result from a behavioural model and
// checks each hand-off, result stability and reset behaviour.
module tb_gcd_engine;

    localparam int N = 6;

    logic clk;
    logic rst;
    logic in_valid;
    logic abort;
    logic out_ready;

    logic [31:0] op_a [N];
    logic [31:0] op_b [N];

    logic [31:0] gcd_w  [N];
    logic [15:0] cyc_w  [N];
    logic        ov_w   [N];
    logic        ir_w   [N];
    logic        busy_w [N];
    logic        ze_w   [N];

    int wid  [N] = '{16, 16, 8, 8, 32, 32};

    int errors = 0;
    int checks = 0;

    // Scoreboard state per instance: expected result of the transaction in
    // flight, last handed-off result, and the held value under back-pressure.
    bit          pending  [N];
    logic [31:0] exp_gcd  [N];
    logic [15:0] exp_cyc  [N];
    logic        exp_ze   [N];
    logic [31:0] last_gcd [N];
    logic [15:0] last_cyc [N];
    logic        last_ze  [N];
    bit          held     [N];
    logic [31:0] hold_gcd [N];
    logic [15:0] hold_cyc [N];
    logic        hold_ze  [N];

    // ---------------- DUT instances ----------------
    for (genvar i = 0; i < N; i++) begin : g_dut
        localparam int W = (i < 2) ? 16 : ((i < 4) ? 8 : 32);
        localparam int M = i % 2;
        gcd_if #(.WIDTH(W), .CYC_W(16)) bus ();
        gcd_engine #(.WIDTH(W), .CYC_W(16), .MODE(M)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
        assign bus.in_valid  = in_valid;
        assign bus.a_in      = op_a[i][W-1:0];
        assign bus.b_in      = op_b[i][W-1:0];
        assign bus.abort     = abort;
        assign bus.out_ready = out_ready;
        assign gcd_w[i]      = 32'(bus.gcd_out);
        assign cyc_w[i]      = bus.cycles_out;
        assign ov_w[i]       = bus.out_valid;
        assign ir_w[i]       = bus.in_ready;
        assign busy_w[i]     = bus.busy;
        assign ze_w[i]       = bus.zero_err;
    end

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference: gcd via Euclid's remainder; subtractive cycle count is the
    // sum of Euclid quotients; binary count follows Stein's rules directly.
    function automatic void model(input longint unsigned a, input longint unsigned b, input int mode,
                                  output longint unsigned g, output longint unsigned cyc, output bit ze);
        longint unsigned x, y, t, n;
        ze = (a == 0) && (b == 0);
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        g = x;
        if (a == 0 || b == 0) begin
            n = 1;
        end else if (mode == 0) begin
            n = 0; x = a; y = b;
            while (y != 0) begin n += x / y; t = x % y; x = y; y = t; end
        end else begin
            n = 1; x = a; y = b;
            while (x != y) begin
                if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
                else if (x % 2 == 0) x = x / 2;
                else if (y % 2 == 0) y = y / 2;
                else if (x > y) x = x - y;
                else y = y - x;
                n++;
            end
        end
        cyc = (n > 65535) ? 65535 : n;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            longint unsigned ma, mb, mg, mc, mask;
            bit mz;
            if (rst) begin
                pending[i] = 1'b0;
                held[i]    = 1'b0;
                continue;
            end
            if (ov_w[i]) begin
                chk($sformatf("in_ready_in_done[%0d]", i), ir_w[i], 0);
                chk($sformatf("busy_in_done[%0d]", i), busy_w[i], 0);
                if (held[i]) begin
                    chk($sformatf("hold_gcd[%0d]", i), gcd_w[i], hold_gcd[i]);
                    chk($sformatf("hold_cyc[%0d]", i), cyc_w[i], hold_cyc[i]);
                    chk($sformatf("hold_ze[%0d]", i), ze_w[i], hold_ze[i]);
                end
                if (out_ready) begin
                    if (!pending[i]) begin
                        chk($sformatf("unexpected_result[%0d]", i), 1, 0);
                    end else begin
                        chk($sformatf("gcd[%0d]", i), gcd_w[i], exp_gcd[i]);
                        chk($sformatf("cycles[%0d]", i), cyc_w[i], exp_cyc[i]);
                        chk($sformatf("zero_err[%0d]", i), ze_w[i], exp_ze[i]);
                    end
                    pending[i]  = 1'b0;
                    held[i]     = 1'b0;
                    last_gcd[i] = gcd_w[i];
                    last_cyc[i] = cyc_w[i];
                    last_ze[i]  = ze_w[i];
                end else begin
                    held[i]     = 1'b1;
                    hold_gcd[i] = gcd_w[i];
                    hold_cyc[i] = cyc_w[i];
                    hold_ze[i]  = ze_w[i];
                end
            end
            if (in_valid && ir_w[i]) begin
                mask = (64'd1 << wid[i]) - 1;
                ma = longint'(op_a[i]) & mask;
                mb = longint'(op_b[i]) & mask;
                model(ma, mb, i % 2, mg, mc, mz);
                exp_gcd[i] = mg[31:0];
                exp_cyc[i] = mc[15:0];
                exp_ze[i]  = mz;
                pending[i] = 1'b1;
            end
            if (abort && busy_w[i]) pending[i] = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < N; i++) begin
            op_a[i] = a;
            op_b[i] = b;
        end
    endtask

    task automatic start_all();
        for (int i = 0; i < N; i++) last_gcd[i] = 32'hdead_beef;
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) if (!ir_w[i] || pending[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit all_ov();
        for (int i = 0; i < N; i++) if (!ov_w[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (!all_idle() && n < 2000);
        if (!all_idle()) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_ov(input string name);
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (!all_ov() && n < 2000);
        if (!all_ov()) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic check_reset_values(input string name);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_in_ready[%0d]", name, i), ir_w[i], 1);
            chk($sformatf("%s_busy[%0d]", name, i), busy_w[i], 0);
            chk($sformatf("%s_out_valid[%0d]", name, i), ov_w[i], 0);
            chk($sformatf("%s_gcd[%0d]", name, i), gcd_w[i], 0);
            chk($sformatf("%s_cycles[%0d]", name, i), cyc_w[i], 0);
            chk($sformatf("%s_zero_err[%0d]", name, i), ze_w[i], 0);
        end
    endtask

    task automatic pulse_reset(input string name);
        @(posedge clk); #1 rst = 1'b1;
        #1 check_reset_values(name);
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        longint unsigned mg, mc;
        bit mz;
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        set_ops(0, 0);
        for (int i = 0; i < N; i++) begin
            pending[i] = 0; held[i] = 0; last_gcd[i] = 0; last_cyc[i] = 0; last_ze[i] = 0;
        end

        // Pin the model with hand-computed values.
        model(48, 18, 0, mg, mc, mz);
        chk("model_sub_48_18_gcd", mg, 6);  chk("model_sub_48_18_cyc", mc, 5);
        model(48, 18, 1, mg, mc, mz);
        chk("model_bin_48_18_gcd", mg, 6);  chk("model_bin_48_18_cyc", mc, 7);
        model(255, 255, 1, mg, mc, mz);
        chk("model_bin_255_cyc", mc, 1);
        model(0, 0, 0, mg, mc, mz);
        chk("model_zero_gcd", mg, 0);       chk("model_zero_ze", mz, 1);

        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Directed: 48,18 in both modes.
        set_ops(48, 18); start_all(); wait_idle("t48_18");
        chk("sub48_18_gcd", last_gcd[0], 6); chk("sub48_18_cyc", last_cyc[0], 5);
        chk("sub48_18_ze", last_ze[0], 0);
        chk("bin48_18_gcd", last_gcd[1], 6); chk("bin48_18_cyc", last_cyc[1], 7);

        // a==b: out_valid one cycle after the single CALC cycle.
        set_ops(255, 255); start_all();
        @(negedge clk);
        chk("eq_latency_busy", busy_w[1], 1); chk("eq_latency_ov0", ov_w[1], 0);
        @(negedge clk);
        chk("eq_latency_ov1", ov_w[1], 1);
        wait_idle("t255");
        chk("bin255_gcd", last_gcd[1], 255); chk("bin255_cyc", last_cyc[1], 1);

        // Zero operands.
        set_ops(0, 35); start_all(); wait_idle("t0_35");
        chk("zero_a_gcd", last_gcd[0], 35); chk("zero_a_ze", last_ze[0], 0);
        set_ops(0, 0); start_all(); wait_idle("t0_0");
        chk("zero_both_gcd", last_gcd[1], 0); chk("zero_both_ze", last_ze[1], 1);
        chk("zero_both_cyc", last_cyc[1], 1);

        // Back-pressure: result held, in_valid pulses ignored.
        out_ready = 1'b0;
        set_ops(48, 18); start_all(); wait_ov("bp");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1 in_valid = c[0]; set_ops(99, 33);
            @(negedge clk);
            for (int i = 0; i < N; i++) chk($sformatf("bp_ov[%0d]", i), ov_w[i], 1);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        wait_idle("bp_release");
        chk("bp_gcd", last_gcd[0], 6);

        // Abort in the 5th CALC cycle, then a fresh request.
        set_ops(1000, 1); start_all();
        repeat (3) @(posedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("abort_ov[%0d]", i), ov_w[i], 0);
                chk($sformatf("abort_idle[%0d]", i), ir_w[i], 1);
            end
        end
        set_ops(12, 8); start_all(); wait_idle("after_abort");
        chk("after_abort_gcd0", last_gcd[0], 4); chk("after_abort_gcd1", last_gcd[1], 4);

        // Reset mid-CALC and mid-DONE.
        set_ops(1000, 1); start_all();
        repeat (2) @(posedge clk);
        #2 for (int i = 0; i < N; i++) chk($sformatf("pre_rst_busy[%0d]", i), busy_w[i], 1);
        pulse_reset("rst_calc");
        out_ready = 1'b0;
        set_ops(48, 18); start_all(); wait_ov("rst_done_wait");
        pulse_reset("rst_done");
        out_ready = 1'b1;
        set_ops(21, 14); start_all(); wait_idle("after_rst");
        chk("after_rst_gcd", last_gcd[0], 7);

        // Random sweep.
        for (int t = 0; t < 150; t++) begin
            bit stall;
            for (int p = 0; p < 3; p++) begin
                logic [31:0] a, b, g;
                int sel;
                if (p == 0) begin
                    a = $urandom_range(0, 255); b = $urandom_range(0, 255);
                end else begin
                    g = (p == 1) ? $urandom_range(1, 255) : $urandom_range(1, 16000000);
                    a = g * $urandom_range(0, 255); b = g * $urandom_range(0, 255);
                end
                sel = $urandom_range(0, 9);
                if (sel == 0) a = 0;
                else if (sel == 1) b = 0;
                else if (sel == 2) b = a;
                else if (sel == 3) begin a = 0; b = 0; end
                op_a[2*p] = a; op_b[2*p] = b;
                op_a[2*p+1] = a; op_b[2*p+1] = b;
            end
            stall = ($urandom_range(0, 3) == 0);
            if (stall) out_ready = 1'b0;
            start_all();
            if (stall) begin
                wait_ov("rand_stall");
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            wait_idle("rand");
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
